// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register-file write port: combinational grant,
// registered one-hot enable/index/data, and a saturating conflict counter.
module regfile_wr_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned R0_PROTECT = 1
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [NREQ-1:0]        req,
    input  logic [4*NREQ-1:0]      req_sel,
    input  logic [DATA_W*NREQ-1:0] req_data,
    input  logic                   rf_stall,
    output logic [NREQ-1:0]        gnt,
    output logic [15:0]            rf_wen,
    output logic [3:0]             rf_sel,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [15:0]            conflict_cnt
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned SEL_W = 4;
    localparam int unsigned NREG  = 16;
    localparam int unsigned CNT_W = 16;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NREG-1:0]   wen_q, wen_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PTR_W-1:0]  winner;
    logic              found;
    logic              grant_vld;
    logic [SEL_W-1:0]  sel_mux;
    logic [DATA_W-1:0] data_mux;
    logic [3:0]        n_req;
    logic              r0_drop;

    // First requesting index in circular order starting at ptr
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req[PTR_W'((32'(ptr_q) + k) % NREQ)]) begin
                found  = 1'b1;
                winner = PTR_W'((32'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign grant_vld = clear & ~rf_stall & found;
    assign gnt       = grant_vld ? (NREQ'(1) << winner) : '0;

    always_comb begin
        sel_mux  = '0;
        data_mux = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_mux  = req_sel[SEL_W*i +: SEL_W];
                data_mux = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        n_req = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            n_req = n_req + 4'(req[i]);
        end
    end

    assign r0_drop = (R0_PROTECT != 0) && (sel_mux == '0);

    always_comb begin
        ptr_d   = ptr_q;
        wen_d   = '0;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if (grant_vld) begin
            ptr_d   = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
            sel_d   = sel_mux;
            wdata_d = data_mux;
            if (!r0_drop) begin
                wen_d = NREG'(1) << sel_mux;
            end
        end
        // Counter saturates instead of wrapping
        if (!rf_stall && (n_req >= 4'd2) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            ptr_q   <= '0;
            wen_q   <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rf_wen       = wen_q;
    assign rf_sel       = sel_q;
    assign rf_wdata     = wdata_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter; a second instance with R0_PROTECT=0
// shares the stimulus so the R0 write path can be compared.
module tb_regfile_wr_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned DATA_W = 32;

    logic                   clock;
    logic                   clear;
    logic [NREQ-1:0]        req;
    logic [4*NREQ-1:0]      req_sel;
    logic [DATA_W*NREQ-1:0] req_data;
    logic                   rf_stall;

    logic [NREQ-1:0]   gnt,      gnt_b;
    logic [15:0]       rf_wen,   rf_wen_b;
    logic [3:0]        rf_sel,   rf_sel_b;
    logic [DATA_W-1:0] rf_wdata, rf_wdata_b;
    logic [15:0]       conflict_cnt, conflict_cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .R0_PROTECT(1)) u_dut (
        .clock(clock), .clear(clear), .req(req), .req_sel(req_sel),
        .req_data(req_data), .rf_stall(rf_stall), .gnt(gnt), .rf_wen(rf_wen),
        .rf_sel(rf_sel), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
    );

    regfile_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .R0_PROTECT(0)) u_dut_nr0 (
        .clock(clock), .clear(clear), .req(req), .req_sel(req_sel),
        .req_data(req_data), .rf_stall(rf_stall), .gnt(gnt_b), .rf_wen(rf_wen_b),
        .rf_sel(rf_sel_b), .rf_wdata(rf_wdata_b), .conflict_cnt(conflict_cnt_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [3:0] s, input logic [31:0] d);
        req_sel[4*i +: 4]   = s;
        req_data[32*i +: 32] = d;
    endtask

    // Inputs change and outputs are sampled on the falling edge
    initial begin
        clear    = 1'b0;
        req      = '0;
        req_sel  = '0;
        req_data = '0;
        rf_stall = 1'b0;

        // Reset then single requester
        repeat (2) @(negedge clock);
        check("rst_wen", 64'(rf_wen), 64'h0);
        check("rst_sel", 64'(rf_sel), 64'h0);
        check("rst_wdata", 64'(rf_wdata), 64'h0);
        check("rst_cnt", 64'(conflict_cnt), 64'h0);
        check("rst_gnt", 64'(gnt), 64'h0);
        clear = 1'b1;
        req   = 4'b0100;
        set_src(2, 4'd5, 32'hDEADBEEF);
        #1 check("single_gnt", 64'(gnt), 64'h4);
        @(negedge clock);
        check("single_wen", 64'(rf_wen), 64'h0020);
        check("single_sel", 64'(rf_sel), 64'h5);
        check("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        req = '0;
        #1 check("idle_gnt", 64'(gnt), 64'h0);
        @(negedge clock);
        check("single_wen_off", 64'(rf_wen), 64'h0);
        // ptr must now be 3: requester 3 beats requester 0
        req = 4'b1001;
        set_src(0, 4'd7, 32'h0000_0070);
        set_src(3, 4'd8, 32'h0000_0080);
        #1 check("ptr3_gnt", 64'(gnt), 64'h8);
        @(negedge clock);
        check("ptr3_wen", 64'(rf_wen), 64'h0100);
        check("ptr3_cnt", 64'(conflict_cnt), 64'h1);

        // Round-robin fairness from reset
        clear = 1'b0;
        req   = '0;
        @(negedge clock);
        clear = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 4; i++) set_src(i, 4'(i + 1), 32'(32'hA000_0000 + i));
        for (int k = 0; k < 8; k++) begin
            #1 check($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(4'b0001 << (k % 4)));
            @(negedge clock);
            check($sformatf("rr_wen%0d", k), 64'(rf_wen), 64'(16'h1 << ((k % 4) + 1)));
            check($sformatf("rr_wdata%0d", k), 64'(rf_wdata), 64'(32'hA000_0000 + (k % 4)));
        end
        check("rr_cnt", 64'(conflict_cnt), 64'd8);

        // Stall holds grants and the counter
        req      = 4'b0011;
        rf_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("stall_gnt%0d", k), 64'(gnt), 64'h0);
            @(negedge clock);
            check($sformatf("stall_wen%0d", k), 64'(rf_wen), 64'h0);
            check($sformatf("stall_cnt%0d", k), 64'(conflict_cnt), 64'd8);
        end
        rf_stall = 1'b0;
        #1 check("unstall_gnt0", 64'(gnt), 64'h1);
        @(negedge clock);
        check("unstall_wen0", 64'(rf_wen), 64'h0002);
        req = 4'b0010;
        #1 check("unstall_gnt1", 64'(gnt), 64'h2);
        @(negedge clock);
        check("unstall_wen1", 64'(rf_wen), 64'h0004);
        check("unstall_cnt", 64'(conflict_cnt), 64'd9);

        // R0 write: acknowledged, enable suppressed only when protected
        req = 4'b0010;
        set_src(1, 4'd0, 32'h1234_5678);
        #1 check("r0_gnt", 64'(gnt), 64'h2);
        check("r0_gnt_b", 64'(gnt_b), 64'h2);
        @(negedge clock);
        check("r0_wen", 64'(rf_wen), 64'h0);
        check("r0_sel", 64'(rf_sel), 64'h0);
        check("r0_wdata", 64'(rf_wdata), 64'h1234_5678);
        check("r0_wen_b", 64'(rf_wen_b), 64'h0001);
        // ptr=2 after the R0 grant
        req = 4'b0101;
        #1 check("ptr2_gnt", 64'(gnt), 64'h4);
        @(negedge clock);
        check("ptr2_wen", 64'(rf_wen), 64'h0008);
        check("ptr2_cnt", 64'(conflict_cnt), 64'd10);

        // Reset right after a grant to requester 3
        req = 4'b1000;
        set_src(3, 4'd9, 32'hCAFE_F00D);
        set_src(1, 4'd6, 32'h0000_0666);
        #1 check("mid_gnt3", 64'(gnt), 64'h8);
        @(negedge clock);
        check("mid_wen3", 64'(rf_wen), 64'h0200);
        clear = 1'b0;
        req   = 4'b0010;
        #1 check("mid_rst_gnt", 64'(gnt), 64'h0);
        @(negedge clock);
        check("mid_rst_wen", 64'(rf_wen), 64'h0);
        check("mid_rst_sel", 64'(rf_sel), 64'h0);
        check("mid_rst_wdata", 64'(rf_wdata), 64'h0);
        check("mid_rst_cnt", 64'(conflict_cnt), 64'h0);
        clear = 1'b1;
        req   = 4'b1010;
        #1 check("mid_ptr0_gnt", 64'(gnt), 64'h2);
        @(negedge clock);
        check("mid_ptr0_wen", 64'(rf_wen), 64'h0040);
        check("mid_ptr0_wdata", 64'(rf_wdata), 64'h0000_0666);

        // Counter saturation
        clear = 1'b0;
        req   = '0;
        @(negedge clock);
        clear = 1'b1;
        req   = 4'b0011;
        set_src(0, 4'd1, 32'h1);
        set_src(1, 4'd2, 32'h2);
        repeat (65534) @(negedge clock);
        check("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
        @(negedge clock);
        check("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
        repeat (5) @(negedge clock);
        check("sat_hold", 64'(conflict_cnt), 64'hFFFF);
        check("sat_hold_b", 64'(conflict_cnt_b), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
